// File: rtl/hpsp_bram_reader_pkg.sv
// Shared types and sizing helpers for the line-buffer port-B read engine.
package hpsp_bram_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int addr_w_f(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int len_w_f(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int fifo_depth_f(input int rd_latency);
        return rd_latency + 1;
    endfunction

    // Width able to hold every value 0..depth.
    function automatic int cnt_w_f(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Never below one bit, so a single-entry FIFO still has a pointer.
    function automatic int ptr_w_f(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/hpsp_skid_fifo.sv
// Register-based synchronous FIFO that absorbs RAM read latency and stream backpressure.
module hpsp_skid_fifo
    import hpsp_bram_reader_pkg::*;
#(
    parameter  int WIDTH = 679,
    parameter  int DEPTH = 1,
    localparam int CNT_W = cnt_w_f(DEPTH)
) (
    input  logic             clka,
    input  logic             aresetn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int               PTR_W    = ptr_w_f(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem[rd_ptr_q];

    // A full FIFO still takes a push when its head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clka or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; pointers and count alone define which entries are live.
    always_ff @(posedge clka) begin
        if (do_push) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/hpsp_bram_reader.sv
// Drains a programmed run of line-buffer entries through port B as a valid/ready stream,
// issuing reads only while the skid FIFO has a credit for the returning data.
module hpsp_bram_reader
    import hpsp_bram_reader_pkg::*;
#(
    parameter  int RAM_WIDTH  = 678,
    parameter  int RAM_DEPTH  = 16,
    parameter  int RD_LATENCY = 0,
    localparam int ADDR_W     = addr_w_f(RAM_DEPTH),
    localparam int LEN_W      = len_w_f(RAM_DEPTH),
    localparam int FIFO_DEPTH = fifo_depth_f(RD_LATENCY)
) (
    input  logic                 clka,
    input  logic                 aresetn,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [ADDR_W-1:0]    start_addr,
    input  logic [LEN_W-1:0]     start_len,
    output logic                 ram_enb,
    output logic [ADDR_W-1:0]    ram_addrb,
    input  logic [RAM_WIDTH-1:0] ram_doutb,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [RAM_WIDTH-1:0] m_data,
    output logic                 m_last,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W  = cnt_w_f(FIFO_DEPTH);
    localparam int CRED_W = cnt_w_f(2 * FIFO_DEPTH);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  remaining_q;
    logic              done_q;
    logic              done_d;

    logic              accept;
    logic              issue;
    logic              pop;
    logic              push;
    logic              push_last;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [RAM_WIDTH:0] fifo_dout;
    logic [CRED_W-1:0] inflight;
    logic [CRED_W-1:0] occupancy;

    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign accept      = start_valid && start_ready;
    assign pop         = m_valid && m_ready;

    // Entries already committed to the FIFO once this cycle's pop leaves.
    assign occupancy = inflight + CRED_W'(fifo_count) - CRED_W'(pop);
    assign issue     = (state_q == READ) && (remaining_q != '0)
                       && (occupancy < CRED_W'(FIFO_DEPTH));

    assign ram_enb   = issue;
    assign ram_addrb = addr_q;
    assign done      = done_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (start_len == '0) done_d  = 1'b1;
                    else                 state_d = READ;
                end
            end
            READ: begin
                if (issue && (remaining_q == LEN_W'(1))) state_d = DRAIN;
            end
            DRAIN: begin
                // Nothing in flight or buffered after this pop: the last beat is leaving now.
                if (occupancy == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clka or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (accept) begin
                addr_q      <= start_addr;
                remaining_q <= start_len;
            end else if (issue) begin
                addr_q      <= addr_q + ADDR_W'(1);
                remaining_q <= remaining_q - LEN_W'(1);
            end
        end
    end

    generate
        if (RD_LATENCY == 0) begin : g_no_pipe
            assign push      = issue;
            assign push_last = issue && (remaining_q == LEN_W'(1));
            assign inflight  = '0;
        end else begin : g_tag_pipe
            logic [RD_LATENCY-1:0] tag_vld_q;
            logic [RD_LATENCY-1:0] tag_last_q;

            always_ff @(posedge clka or negedge aresetn) begin
                if (!aresetn) begin
                    tag_vld_q  <= '0;
                    tag_last_q <= '0;
                end else begin
                    tag_vld_q[0]  <= issue;
                    tag_last_q[0] <= issue && (remaining_q == LEN_W'(1));
                    for (int i = 1; i < RD_LATENCY; i++) begin
                        tag_vld_q[i]  <= tag_vld_q[i-1];
                        tag_last_q[i] <= tag_last_q[i-1];
                    end
                end
            end

            always_comb begin
                inflight = '0;
                for (int i = 0; i < RD_LATENCY; i++) begin
                    inflight = inflight + CRED_W'(tag_vld_q[i]);
                end
            end

            assign push      = tag_vld_q[RD_LATENCY-1];
            assign push_last = tag_last_q[RD_LATENCY-1];
        end
    endgenerate

    hpsp_skid_fifo #(
        .WIDTH (RAM_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_skid_fifo (
        .clka    (clka),
        .aresetn (aresetn),
        .push    (push),
        .din     ({push_last, ram_doutb}),
        .pop     (pop),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Head is masked while empty so the stream outputs read as zero after reset.
    assign m_valid = !fifo_empty;
    assign m_data  = m_valid ? fifo_dout[RAM_WIDTH-1:0] : '0;
    assign m_last  = m_valid && fifo_dout[RAM_WIDTH];

    a_no_overflow : assert property (@(posedge clka) disable iff (!aresetn)
        !(push && fifo_full && !pop));

endmodule

// File: tb/tb_hpsp_bram_reader.sv
// Randomized self-checking bench: three readers (RD_LATENCY 0,1,2) against a queue-based run model.
module tb_hpsp_bram_reader;

    localparam int W  = 678;
    localparam int D  = 16;
    localparam int AW = 4;
    localparam int LW = 5;
    localparam int NI = 3;

    logic clka    = 1'b0;
    logic aresetn = 1'b0;
    always #5 clka = ~clka;

    logic [W-1:0]  mem [D];
    logic          sv [NI];
    logic          sr [NI];
    logic [AW-1:0] sa [NI];
    logic [LW-1:0] sl [NI];
    logic          enb [NI];
    logic [AW-1:0] addrb [NI];
    logic [W-1:0]  dout [NI];
    logic          mv [NI];
    logic          mr [NI];
    logic [W-1:0]  md [NI];
    logic          ml [NI];
    logic          bsy [NI];
    logic          dn [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        hpsp_bram_reader #(
            .RAM_WIDTH  (W),
            .RAM_DEPTH  (D),
            .RD_LATENCY (g)
        ) u_dut (
            .clka        (clka),
            .aresetn     (aresetn),
            .start_valid (sv[g]),
            .start_ready (sr[g]),
            .start_addr  (sa[g]),
            .start_len   (sl[g]),
            .ram_enb     (enb[g]),
            .ram_addrb   (addrb[g]),
            .ram_doutb   (dout[g]),
            .m_valid     (mv[g]),
            .m_ready     (mr[g]),
            .m_data      (md[g]),
            .m_last      (ml[g]),
            .busy        (bsy[g]),
            .done        (dn[g])
        );

        // Port-B model: enb-gated read register, further output stages always enabled.
        if (g == 0) begin : g_ram_comb
            assign dout[g] = mem[addrb[g]];
        end else begin : g_ram_reg
            logic [W-1:0] rd_pipe [g];
            always @(posedge clka) begin
                if (enb[g]) rd_pipe[0] <= mem[addrb[g]];
                for (int i = 1; i < g; i++) rd_pipe[i] <= rd_pipe[i-1];
            end
            assign dout[g] = rd_pipe[g-1];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [703:0] got, input logic [703:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Observation of the selected instance, sampled on the falling edge.
    int            cur = 0;
    int            cyc = 0;
    int            enb_cnt = 0;
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            first_pop_cyc = 0;
    int            last_pop_cyc = 0;
    logic          done_busy = 1'b0;
    logic          prev_stall = 1'b0;
    logic [W:0]    prev_beat = '0;
    logic [AW-1:0] addr_obs [$];
    logic [W:0]    beat_obs [$];
    logic [AW-1:0] exp_a [$];
    logic [W:0]    exp_b [$];

    always @(negedge clka) begin
        cyc++;
        if (!aresetn) begin
            prev_stall = 1'b0;
        end else begin
            if (enb[cur]) begin
                enb_cnt++;
                addr_obs.push_back(addrb[cur]);
            end
            if (prev_stall) check("hold", {mv[cur], ml[cur], md[cur]}, {1'b1, prev_beat});
            if (mv[cur] && mr[cur]) begin
                if (beat_obs.size() == 0) first_pop_cyc = cyc;
                beat_obs.push_back({ml[cur], md[cur]});
                last_pop_cyc = cyc;
            end
            if (dn[cur]) begin
                done_cnt++;
                done_cyc  = cyc;
                done_busy = bsy[cur];
            end
            check("credit", (enb_cnt - beat_obs.size()) <= cur + 1, 1'b1);
            prev_stall = mv[cur] && !mr[cur];
            prev_beat  = {ml[cur], md[cur]};
        end
    end

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic select(input int k);
        cur      = k;
        enb_cnt  = 0;
        done_cnt = 0;
        addr_obs.delete();
        beat_obs.delete();
        exp_a.delete();
        exp_b.delete();
    endtask

    // Reference model: a run of n entries from a yields entries a, a+1, ... modulo depth.
    task automatic model_run(input int a, input int n);
        for (int i = 0; i < n; i++) begin
            exp_a.push_back(AW'((a + i) % D));
            exp_b.push_back({(i == n - 1), mem[(a + i) % D]});
        end
    endtask

    task automatic compare(input int ndone);
        check("beat_count", beat_obs.size(), exp_b.size());
        check("enb_count", enb_cnt, exp_a.size());
        for (int i = 0; i < exp_b.size(); i++)
            if (i < beat_obs.size()) check("beat", beat_obs[i], exp_b[i]);
        for (int i = 0; i < exp_a.size(); i++)
            if (i < addr_obs.size()) check("addrb", addr_obs[i], exp_a[i]);
        check("done_count", done_cnt, ndone);
    endtask

    task automatic check_reset(input int k);
        check("rst_start_ready", sr[k], 1'b1);
        check("rst_busy", bsy[k], 1'b0);
        check("rst_enb", enb[k], 1'b0);
        check("rst_addrb", addrb[k], '0);
        check("rst_m_valid", mv[k], 1'b0);
        check("rst_m_data", md[k], '0);
        check("rst_m_last", ml[k], 1'b0);
        check("rst_done", dn[k], 1'b0);
    endtask

    task automatic run_one(input int k, input int a, input int n, input int pct, input int stall_at);
        int t;
        int acc_cyc;
        int e_mid;
        logic stalled;
        select(k);
        model_run(a, n);
        t = 0;
        while (!sr[k] && t < 100) begin
            tick();
            t++;
        end
        mr[k] = 1'b1;
        sv[k] = 1'b1;
        sa[k] = AW'(a);
        sl[k] = LW'(n);
        @(posedge clka);
        acc_cyc = cyc;
        #1;
        sv[k] = 1'b0;
        stalled = 1'b0;
        e_mid = 0;
        t = 0;
        while (done_cnt == 0 && t < 500) begin
            if (stall_at >= 0 && !stalled && beat_obs.size() >= stall_at) begin
                stalled = 1'b1;
                mr[k] = 1'b0;
                for (int s = 0; s < 10; s++) begin
                    tick();
                    if (s == 4) e_mid = enb_cnt;
                end
                check("stall_buffered", enb_cnt - beat_obs.size(), k + 1);
                check("stall_no_enb", enb_cnt, e_mid);
            end
            mr[k] = ($urandom_range(0, 99) >= pct);
            tick();
            t++;
        end
        if (done_cnt == 0) check("done_timeout", 1'b0, 1'b1);
        mr[k] = 1'b1;
        repeat (3) tick();
        compare(1);
        if (n == 0) check("done_lat_len0", done_cyc, acc_cyc + 1);
        else        check("done_lat", done_cyc, last_pop_cyc + 1);
        check("done_idle", done_busy, 1'b0);
        if (pct == 0 && stall_at < 0 && n > 0)
            check("throughput", last_pop_cyc - first_pop_cyc, n - 1);
    endtask

    // Back-to-back runs with start_valid held high; requests made while busy must wait.
    task automatic run_b2b(input int k, input int nruns, input int pct);
        int a [$];
        int n [$];
        int t;
        logic was_ready;
        select(k);
        for (int r = 0; r < nruns; r++) begin
            a.push_back($urandom_range(0, D - 1));
            n.push_back((r == 1) ? 0 : (r == 2) ? D : $urandom_range(1, D));
            model_run(a[r], n[r]);
        end
        for (int r = 0; r < nruns; r++) begin
            sv[k] = 1'b1;
            sa[k] = AW'(a[r]);
            sl[k] = LW'(n[r]);
            t = 0;
            do begin
                was_ready = sr[k];
                mr[k] = ($urandom_range(0, 99) >= pct);
                tick();
                t++;
            end while (!was_ready && t < 1000);
            if (!was_ready) check("accept_timeout", 1'b0, 1'b1);
        end
        sv[k] = 1'b0;
        t = 0;
        while (done_cnt < nruns && t < 2000) begin
            mr[k] = ($urandom_range(0, 99) >= pct);
            tick();
            t++;
        end
        mr[k] = 1'b1;
        repeat (3) tick();
        compare(nruns);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        for (int k = 0; k < NI; k++) begin
            sv[k] = 1'b0;
            sa[k] = '0;
            sl[k] = '0;
            mr[k] = 1'b0;
        end
        for (int i = 0; i < D; i++) begin
            logic [703:0] w;
            for (int j = 0; j < 22; j++) w[j*32 +: 32] = $urandom;
            mem[i] = w[W-1:0];
        end
        #1;
        for (int k = 0; k < NI; k++) check_reset(k);
        repeat (3) @(posedge clka);
        #1;
        aresetn = 1'b1;
        tick();

        run_one(2, 3, 4, 0, -1);
        run_one(2, 14, 4, 0, -1);
        run_one(2, 0, 0, 0, -1);
        run_one(2, 7, 16, 0, -1);
        run_one(2, 5, 16, 0, 3);

        // Abort a run with two reads in flight, then start afresh.
        select(2);
        mr[2] = 1'b0;
        sv[2] = 1'b1;
        sa[2] = '0;
        sl[2] = LW'(8);
        tick();
        sv[2] = 1'b0;
        t = 0;
        while (enb_cnt < 2 && t < 50) begin
            tick();
            t++;
        end
        check("pre_reset_issued", enb_cnt, 2);
        aresetn = 1'b0;
        #1;
        check_reset(2);
        repeat (2) tick();
        aresetn = 1'b1;
        tick();
        run_one(2, 9, 5, 20, -1);

        for (int k = 0; k < NI; k++) begin
            run_one(k, $urandom_range(0, D - 1), $urandom_range(1, D), 0, -1);
            run_one(k, $urandom_range(0, D - 1), $urandom_range(1, D), 40, -1);
            run_b2b(k, 6, 30);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
